// File: rtl/multicycle_ctrl_if.sv
// Control <-> datapath/memory bundle for the multicycle riscv32 core.
// master = control FSM side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       funct7_0;
  logic       Zflag;
  logic       mem_ready;
  logic [3:0] ALUcontrol;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       mem_req;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7_5, funct7_0, Zflag, mem_ready,
    output ALUcontrol, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, AdrSrc,
           mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7_5, funct7_0, Zflag, mem_ready,
    input  ALUcontrol, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, AdrSrc,
           mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle riscv32 control FSM; outputs are combinational from state and IR fields.
// Memory states hold mem_req/AdrSrc until mem_ready; beq/bne 3, R/I/sw 4, lw 5 cycles.
module multicycle_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  state_t     state_q, state_d;
  logic [3:0] f3_alu;
  logic       f3_ok;
  logic [3:0] alu_c;
  logic [1:0] srca_c, srcb_c, imm_c, res_c;
  logic       adr_c, req_c, mw_c, irw_c, pcw_c, rw_c, ill_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // funct3 -> ALU op shared by R and I forms; 011 (sltu) is not supported
  always_comb begin
    f3_alu = ALU_ADD;
    f3_ok  = 1'b1;
    case (bus.funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b111:  f3_alu = ALU_AND;
      3'b110:  f3_alu = ALU_OR;
      3'b001:  f3_alu = ALU_SLL;
      3'b101:  f3_alu = ALU_SRL;
      3'b100:  f3_alu = ALU_XOR;
      3'b010:  f3_alu = ALU_SLT;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    alu_c   = ALU_ADD;
    srca_c  = 2'b00;
    srcb_c  = 2'b00;
    imm_c   = 2'b00;
    res_c   = 2'b00;
    adr_c   = 1'b0;
    req_c   = 1'b0;
    mw_c    = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    rw_c    = 1'b0;
    ill_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        srcb_c = 2'b10;
        res_c  = 2'b10;
        if (bus.mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        srca_c = 2'b01;
        srcb_c = 2'b01;
        // jal needs its J immediate for the target; everything else uses B
        imm_c  = (bus.opcode == OP_JAL) ? 2'b11 : 2'b10;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        srca_c  = 2'b10;
        srcb_c  = 2'b01;
        imm_c   = bus.opcode[5] ? 2'b01 : 2'b00;
        state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c = 1'b1;
        adr_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_c   = 2'b01;
        rw_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c = 1'b1;
        mw_c  = 1'b1;
        adr_c = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        srca_c  = 2'b10;
        state_d = S_ALUWB;
        if (bus.funct7_0) begin
          if (!bus.funct7_5 && bus.funct3 == 3'b000) alu_c = ALU_MUL;
          else                                       state_d = S_TRAP;
        end else if (bus.funct7_5) begin
          if (bus.funct3 == 3'b000) alu_c = ALU_SUB;
          else                      state_d = S_TRAP;
        end else if (f3_ok) begin
          alu_c = f3_alu;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXECI: begin
        srca_c  = 2'b10;
        srcb_c  = 2'b01;
        alu_c   = f3_alu;
        state_d = f3_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        rw_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca_c  = 2'b10;
        alu_c   = ALU_SUB;
        pcw_c   = bus.funct3[0] ? ~bus.Zflag : bus.Zflag;
        state_d = S_FETCH;
      end
      S_JAL: begin
        srca_c  = 2'b01;
        srcb_c  = 2'b10;
        pcw_c   = 1'b1;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        ill_c = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // rst masks everything combinationally so no enable escapes in the cycle it rises
  assign bus.ALUcontrol = rst ? 4'b0000 : alu_c;
  assign bus.ALUSrcA    = rst ? 2'b00 : srca_c;
  assign bus.ALUSrcB    = rst ? 2'b00 : srcb_c;
  assign bus.ImmSrc     = rst ? 2'b00 : imm_c;
  assign bus.ResultSrc  = rst ? 2'b00 : res_c;
  assign bus.AdrSrc     = ~rst & adr_c;
  assign bus.mem_req    = ~rst & req_c;
  assign bus.MemWrite   = ~rst & mw_c;
  assign bus.IRWrite    = ~rst & irw_c;
  assign bus.PCWrite    = ~rst & pcw_c;
  assign bus.RegWrite   = ~rst & rw_c;
  assign bus.illegal    = ~rst & ill_c;
  assign bus.state      = state_q;
endmodule
